led_counter_ctrl: RTL and testbench

Parametrised counter core for iCE40 board examples that replaces the fixed free-running N-bit LED counter. It adds a clock prescaler, count enable, up/down direction, synchronous load, and a free-run or one-shot mode with a start/done handshake. The most-significant counter bits drive the board LEDs. It sits directly between the board clock and the LED pins, or feeds other example logic through `tc` and `done`.

---
 rtl/led_counter_pkg.sv | 13 +
 rtl/led_counter_ctrl_tick_gen.sv | 35 +++
 rtl/led_counter_ctrl.sv | 81 ++++++++
 tb/tb_led_counter_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/led_counter_pkg.sv
// rtl/led_counter_pkg.sv - shared state encoding and mode constants for led_counter_ctrl
package led_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/led_counter_ctrl_tick_gen.sv
// rtl/led_counter_ctrl_tick_gen.sv - enabled prescaler producing one count tick per 2^PRESC enabled clocks
module tick_gen #(
  parameter int PRESC = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESC == 0) begin : g_direct
      logic unused_direct;
      assign unused_direct = ^{clk, rstn, clr};
      assign tick = en;
    end else begin : g_presc
      logic [PRESC-1:0] presc;

      // Clear beats enable so the first tick after start is a full period away.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          presc <= '0;
        end else if (clr) begin
          presc <= '0;
        end else if (en) begin
          presc <= presc + {{(PRESC-1){1'b0}}, 1'b1};
        end
      end

      assign tick = en && (presc == {PRESC{1'b1}});
    end
  endgenerate

endmodule

// File: rtl/led_counter_ctrl.sv
// rtl/led_counter_ctrl.sv - prescaled up/down LED counter with free-run/one-shot modes and start/done handshake
module led_counter_ctrl
  import led_counter_pkg::*;
#(
  parameter int N     = 24,
  parameter int PRESC = 0,
  parameter int LEDS  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            dir,
  input  logic            mode,
  input  logic            start,
  input  logic            load,
  input  logic [N-1:0]    load_val,
  output logic [N-1:0]    count,
  output logic [LEDS-1:0] leds,
  output logic            tc,
  output logic            done
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state, state_nx;
  logic [N-1:0]   count_nx;
  logic [N-1:0]   term;
  logic           tc_nx;
  logic           tick;

  tick_gen #(.PRESC(PRESC)) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (start),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      tc    <= tc_nx;
      done  <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    tc_nx    = 1'b0;
    term     = dir ? {N{1'b1}} : {N{1'b0}};

    if (start) begin
      count_nx = load_val;
      state_nx = RUN;
    end else if (load) begin
      count_nx = load_val;
    end else if (tick && state == RUN) begin
      // Free-run wrap falls out of modulo arithmetic; only one-shot must hold.
      if (count == term) begin
        tc_nx = 1'b1;
        if (mode == MODE_ONESHOT) begin
          state_nx = DONE;
        end else begin
          count_nx = dir ? count + ONE : count - ONE;
        end
      end else begin
        count_nx = dir ? count + ONE : count - ONE;
      end
    end
  end

  assign leds = count[N-1 -: LEDS];

endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb/tb_led_counter_ctrl.sv - directed table and sequence checks for led_counter_ctrl
module tb_led_counter_ctrl;

  typedef struct {
    int en, dir, mode, start, load, lv;
    int cnt, tc, done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn, en, dir, mode, start, load;
  logic [5:0] load_val;

  logic [5:0] c0, c1, c2;
  logic [2:0] l0, l1, l2;
  logic       t0, t1, t2, d0, d1, d2;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  led_counter_ctrl #(.N(6), .PRESC(0), .LEDS(3)) u0 (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_val(load_val), .count(c0), .leds(l0), .tc(t0), .done(d0));
  led_counter_ctrl #(.N(6), .PRESC(1), .LEDS(3)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_val(load_val), .count(c1), .leds(l1), .tc(t1), .done(d1));
  led_counter_ctrl #(.N(6), .PRESC(2), .LEDS(3)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_val(load_val), .count(c2), .leds(l2), .tc(t2), .done(d2));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int e, input int d, input int m, input int s, input int l, input int v);
    en       = e[0];
    dir      = d[0];
    mode     = m[0];
    start    = s[0];
    load     = l[0];
    load_val = v[5:0];
  endtask

  initial begin
    int exp_cnt;
    int ledv;

    rstn = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    step();
    step();
    chk("reset_count_p0", int'(c0), 0);
    chk("reset_count_p2", int'(c2), 0);
    chk("reset_leds", int'(l0), 0);
    chk("reset_tc", int'(t0), 0);
    chk("reset_done", int'(d0), 0);
    rstn = 1'b1;

    // Idle: enabled but never started.
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_count_p0", int'(c0), 0);
      chk("idle_count_p2", int'(c2), 0);
      chk("idle_leds", int'(l0), 0);
      chk("idle_tc", int'(t0), 0);
      chk("idle_done", int'(d0), 0);
    end

    //                 en dir mode st ld  lv   cnt tc done
    tbl.push_back('{1, 1, 0, 1, 0, 60, 60, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 61, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 62, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 63, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0,  0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0,  1, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 17, 17, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 18, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 17, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 17, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 1,  5,  5, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0,  6, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0,  1,  1, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 0,  0,  0, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 0,  0,  0, 1, 1});
    tbl.push_back('{1, 0, 1, 0, 0,  0,  0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0,  0,  0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 1,  9,  9, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0,  0,  9, 0, 1});
    tbl.push_back('{1, 1, 0, 1, 0, 62, 62, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 63, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 62, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1,  0,  0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 63, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 62, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].start, tbl[i].load, tbl[i].lv);
      step();
      ledv = tbl[i].cnt / 8;
      chk($sformatf("vec%0d_count", i), int'(c0), tbl[i].cnt);
      chk($sformatf("vec%0d_leds", i), int'(l0), ledv);
      chk($sformatf("vec%0d_tc", i), int'(t0), tbl[i].tc);
      chk($sformatf("vec%0d_done", i), int'(d0), tbl[i].done);
    end

    // One-shot down on the PRESC=2 instance: a tick every 4 enabled clocks.
    drive(1, 0, 1, 1, 0, 3);
    step();
    chk("os_start_count", int'(c2), 3);
    drive(1, 0, 1, 0, 0, 0);
    exp_cnt = 3;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i % 4 == 0 && exp_cnt > 0) exp_cnt--;
      chk($sformatf("os_count_%0d", i), int'(c2), exp_cnt);
      chk($sformatf("os_tc_%0d", i), int'(t2), (i == 16) ? 1 : 0);
      chk($sformatf("os_done_%0d", i), int'(d2), (i == 16) ? 1 : 0);
    end
    step();
    chk("os_hold_count", int'(c2), 0);
    chk("os_hold_tc", int'(t2), 0);
    chk("os_hold_done", int'(d2), 1);

    // Enable freeze and direction flip on the PRESC=1 instance.
    drive(1, 1, 0, 1, 0, 8);
    step();
    chk("en_start", int'(c1), 8);
    drive(1, 1, 0, 0, 0, 0);
    step();
    chk("en_phase0", int'(c1), 8);
    step();
    chk("en_tick1", int'(c1), 9);
    step();
    chk("en_phase1", int'(c1), 9);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("en_frozen", int'(c1), 9);
      chk("en_frozen_tc", int'(t1), 0);
    end
    en = 1'b1;
    step();
    chk("en_resume_phase", int'(c1), 10);
    dir = 1'b0;
    step();
    chk("dir_wait", int'(c1), 10);
    step();
    chk("dir_flip", int'(c1), 9);

    // Asynchronous reset between edges while running.
    drive(1, 1, 0, 1, 0, 40);
    step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    step();
    chk("ar_pre_count", int'(c0), 42);
    chk("ar_pre_done", int'(d0), 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_count", int'(c0), 0);
    chk("ar_leds", int'(l0), 0);
    chk("ar_tc", int'(t0), 0);
    chk("ar_done", int'(d0), 0);
    chk("ar_count_p1", int'(c1), 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_idle_count", int'(c0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
